// File: rtl/bitwise_result_fifo_if.sv
// Handshake bundle between the 4-bit logic unit, the result FIFO and its consumer.
// The slave side is the FIFO; the master side is whoever drives the upstream results.
interface bitwise_result_fifo_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
);
    logic [WIDTH-1:0]         y0_in;
    logic [WIDTH-1:0]         y1_in;
    logic [WIDTH-1:0]         y2_in;
    logic [WIDTH-1:0]         y3_in;
    logic [WIDTH-1:0]         y4_in;
    logic [WIDTH-1:0]         y5_in;
    logic [WIDTH-1:0]         y6_in;
    logic [2:0]               op_sel_in;
    logic                     in_valid_in;
    logic                     in_ready_out;
    logic [WIDTH-1:0]         res_out;
    logic [2:0]               op_out;
    logic                     zero_out;
    logic                     parity_out;
    logic                     out_valid_out;
    logic                     out_ready_in;
    logic [$clog2(DEPTH):0]   count_out;
    logic                     err_out;

    modport slave (
        input  y0_in, y1_in, y2_in, y3_in, y4_in, y5_in, y6_in,
        input  op_sel_in, in_valid_in, out_ready_in,
        output in_ready_out, res_out, op_out, zero_out, parity_out,
        output out_valid_out, count_out, err_out
    );

    modport master (
        output y0_in, y1_in, y2_in, y3_in, y4_in, y5_in, y6_in,
        output op_sel_in, in_valid_in, out_ready_in,
        input  in_ready_out, res_out, op_out, zero_out, parity_out,
        input  out_valid_out, count_out, err_out
    );
endinterface

// File: rtl/bitwise_result_fifo.sv
// Selects one of seven bitwise results by op code and buffers {op, result} in a
// first-word fall-through FIFO; op code 7 is swallowed and latches a sticky error.
module bitwise_result_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input logic                    clk_in,
    input logic                    rst_n_in,
    bitwise_result_fifo_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = WIDTH + 3;

    logic [EW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             err;
    logic [WIDTH-1:0] sel_res;
    logic [EW-1:0]    head;
    logic             in_ready;
    logic             out_valid;
    logic             push_any;
    logic             push_ok;
    logic             pop;

    always_comb begin
        sel_res = '0;
        case (bus.op_sel_in)
            3'd0:    sel_res = bus.y0_in;
            3'd1:    sel_res = bus.y1_in;
            3'd2:    sel_res = bus.y2_in;
            3'd3:    sel_res = bus.y3_in;
            3'd4:    sel_res = bus.y4_in;
            3'd5:    sel_res = bus.y5_in;
            3'd6:    sel_res = bus.y6_in;
            default: sel_res = '0;
        endcase
    end

    // Ready depends only on occupancy, so nothing on the output side reaches upstream combinationally.
    assign in_ready  = (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push_any  = bus.in_valid_in && in_ready;
    assign push_ok   = push_any && (bus.op_sel_in != 3'd7);
    assign pop       = out_valid && bus.out_ready_in;

    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            mem[wr_ptr] <= {bus.op_sel_in, sel_res};
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push_any && (bus.op_sel_in == 3'd7)) begin
                err <= 1'b1;
            end
        end
    end

    assign head             = mem[rd_ptr];
    assign bus.res_out      = out_valid ? head[WIDTH-1:0] : '0;
    assign bus.op_out       = out_valid ? head[EW-1:WIDTH] : 3'd0;
    assign bus.zero_out     = (bus.res_out == '0) && out_valid;
    assign bus.parity_out   = ^bus.res_out;
    assign bus.in_ready_out = in_ready;
    assign bus.out_valid_out = out_valid;
    assign bus.count_out    = count;
    assign bus.err_out      = err;
endmodule

// File: tb/tb_bitwise_result_fifo.sv
// Directed bench for bitwise_result_fifo: each task drives one scenario and checks
// against hand-computed constants.
module tb_bitwise_result_fifo;
    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    bitwise_result_fifo_if #(.WIDTH(4), .DEPTH(4)) bif ();

    bitwise_result_fifo #(.WIDTH(4), .DEPTH(4)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Upstream logic unit: y0..y6 = NOT a, OR, NOR, AND, NAND, XOR, XNOR.
    task automatic set_ab(input logic [3:0] a, input logic [3:0] b);
        bif.y0_in = ~a;
        bif.y1_in = a | b;
        bif.y2_in = ~(a | b);
        bif.y3_in = a & b;
        bif.y4_in = ~(a & b);
        bif.y5_in = a ^ b;
        bif.y6_in = ~(a ^ b);
    endtask

    task automatic push_one(input logic [2:0] op);
        bif.op_sel_in   = op;
        bif.in_valid_in = 1'b1;
        tick();
        bif.in_valid_in = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        bif.in_valid_in  = 1'b0;
        bif.out_ready_in = 1'b0;
        bif.op_sel_in    = 3'd0;
        set_ab(4'b1010, 4'b0110);
        rst_n = 1'b0;
        #12;
        tests_run++; if (bif.count_out !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_count got %0d expected 0", bif.count_out); end
        tests_run++; if (bif.out_valid_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid got %b expected 0", bif.out_valid_out); end
        tests_run++; if (bif.in_ready_out !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_ready got %b expected 1", bif.in_ready_out); end
        tests_run++; if ({bif.res_out, bif.op_out, bif.zero_out, bif.parity_out} !== 9'd0) begin tests_failed++; $display("[TB] FAIL reset_head got res=%b op=%0d z=%b p=%b expected all 0", bif.res_out, bif.op_out, bif.zero_out, bif.parity_out); end
        tests_run++; if (bif.err_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_err got %b expected 0", bif.err_out); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        bif.out_ready_in = 1'b1;
        tick();
        bif.out_ready_in = 1'b0;
        tests_run++; if (bif.count_out !== 3'd0 || bif.out_valid_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL empty_pop got count=%0d valid=%b expected 0 0", bif.count_out, bif.out_valid_out); end
    endtask

    task automatic test_basic();
        set_ab(4'b1010, 4'b0110);
        push_one(3'd5);
        tests_run++; if (bif.out_valid_out !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_valid got %b expected 1", bif.out_valid_out); end
        tests_run++; if (bif.res_out !== 4'b1100) begin tests_failed++; $display("[TB] FAIL basic_res got %b expected 1100", bif.res_out); end
        tests_run++; if (bif.op_out !== 3'd5) begin tests_failed++; $display("[TB] FAIL basic_op got %0d expected 5", bif.op_out); end
        tests_run++; if (bif.zero_out !== 1'b0 || bif.parity_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_flags got z=%b p=%b expected 0 0", bif.zero_out, bif.parity_out); end
        tests_run++; if (bif.count_out !== 3'd1) begin tests_failed++; $display("[TB] FAIL basic_count got %0d expected 1", bif.count_out); end
        bif.out_ready_in = 1'b1;
        tick();
        bif.out_ready_in = 1'b0;
        tests_run++; if (bif.count_out !== 3'd0 || bif.res_out !== 4'b0000) begin tests_failed++; $display("[TB] FAIL basic_drain got count=%0d res=%b expected 0 0000", bif.count_out, bif.res_out); end
    endtask

    task automatic test_fill_full();
        logic [3:0] exp_res [4];
        logic [2:0] exp_op  [4];
        logic       exp_par [4];
        exp_res = '{4'b1110, 4'b0001, 4'b0010, 4'b0011};
        exp_op  = '{3'd1, 3'd2, 3'd3, 3'd6};
        exp_par = '{1'b1, 1'b1, 1'b1, 1'b0};
        set_ab(4'b1010, 4'b0110);
        for (int i = 0; i < 4; i++) begin
            push_one(3'(i));
        end
        tests_run++; if (bif.count_out !== 3'd4 || bif.in_ready_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_flags got count=%0d ready=%b expected 4 0", bif.count_out, bif.in_ready_out); end
        push_one(3'd5);
        tests_run++; if (bif.count_out !== 3'd4 || bif.res_out !== 4'b0101) begin tests_failed++; $display("[TB] FAIL full_reject got count=%0d head=%b expected 4 0101", bif.count_out, bif.res_out); end
        // Pop while full: the push offered in the same cycle must wait one cycle.
        bif.op_sel_in    = 3'd6;
        bif.in_valid_in  = 1'b1;
        bif.out_ready_in = 1'b1;
        tick();
        bif.out_ready_in = 1'b0;
        tests_run++; if (bif.count_out !== 3'd3 || bif.in_ready_out !== 1'b1) begin tests_failed++; $display("[TB] FAIL full_pop got count=%0d ready=%b expected 3 1", bif.count_out, bif.in_ready_out); end
        tick();
        bif.in_valid_in = 1'b0;
        tests_run++; if (bif.count_out !== 3'd4) begin tests_failed++; $display("[TB] FAIL full_refill got count=%0d expected 4", bif.count_out); end
        for (int i = 0; i < 4; i++) begin
            tests_run++; if (bif.res_out !== exp_res[i] || bif.op_out !== exp_op[i] || bif.parity_out !== exp_par[i]) begin tests_failed++; $display("[TB] FAIL drain_%0d got res=%b op=%0d p=%b expected res=%b op=%0d p=%b", i, bif.res_out, bif.op_out, bif.parity_out, exp_res[i], exp_op[i], exp_par[i]); end
            bif.out_ready_in = 1'b1;
            tick();
            bif.out_ready_in = 1'b0;
        end
        tests_run++; if (bif.count_out !== 3'd0 || bif.out_valid_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL drain_empty got count=%0d valid=%b expected 0 0", bif.count_out, bif.out_valid_out); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_head [8];
        exp_head = '{4'b1110, 4'b0001, 4'b0011, 4'b1101, 4'b0011, 4'b1101, 4'b0011, 4'b1101};
        set_ab(4'b1010, 4'b0110);
        push_one(3'd1);
        push_one(3'd2);
        bif.in_valid_in  = 1'b1;
        bif.out_ready_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bif.op_sel_in = (i % 2 == 0) ? 3'd6 : 3'd4;
            tests_run++; if (bif.res_out !== exp_head[i]) begin tests_failed++; $display("[TB] FAIL b2b_head_%0d got %b expected %b", i, bif.res_out, exp_head[i]); end
            tick();
            tests_run++; if (bif.count_out !== 3'd2) begin tests_failed++; $display("[TB] FAIL b2b_count_%0d got %0d expected 2", i, bif.count_out); end
        end
        bif.in_valid_in = 1'b0;
        for (int i = 6; i < 8; i++) begin
            tests_run++; if (bif.res_out !== exp_head[i]) begin tests_failed++; $display("[TB] FAIL b2b_tail_%0d got %b expected %b", i, bif.res_out, exp_head[i]); end
            tick();
        end
        bif.out_ready_in = 1'b0;
        tests_run++; if (bif.count_out !== 3'd0) begin tests_failed++; $display("[TB] FAIL b2b_empty got %0d expected 0", bif.count_out); end
    endtask

    task automatic test_illegal_op();
        set_ab(4'b1010, 4'b0110);
        tests_run++; if (bif.err_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL illegal_pre_err got %b expected 0", bif.err_out); end
        push_one(3'd7);
        tests_run++; if (bif.err_out !== 1'b1 || bif.count_out !== 3'd0) begin tests_failed++; $display("[TB] FAIL illegal_push got err=%b count=%0d expected 1 0", bif.err_out, bif.count_out); end
        push_one(3'd5);
        tests_run++; if (bif.count_out !== 3'd1 || bif.res_out !== 4'b1100) begin tests_failed++; $display("[TB] FAIL illegal_then_legal got count=%0d res=%b expected 1 1100", bif.count_out, bif.res_out); end
        bif.op_sel_in    = 3'd7;
        bif.in_valid_in  = 1'b1;
        bif.out_ready_in = 1'b1;
        tick();
        bif.in_valid_in  = 1'b0;
        bif.out_ready_in = 1'b0;
        tests_run++; if (bif.count_out !== 3'd0 || bif.err_out !== 1'b1) begin tests_failed++; $display("[TB] FAIL illegal_with_pop got count=%0d err=%b expected 0 1", bif.count_out, bif.err_out); end
        pulse_reset();
        tests_run++; if (bif.err_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL illegal_cleared got %b expected 0", bif.err_out); end
    endtask

    task automatic test_zero_flag();
        set_ab(4'b1111, 4'b0000);
        push_one(3'd3);
        tests_run++; if (bif.res_out !== 4'b0000 || bif.zero_out !== 1'b1 || bif.parity_out !== 1'b0 || bif.op_out !== 3'd3) begin tests_failed++; $display("[TB] FAIL zero_flag got res=%b z=%b p=%b op=%0d expected 0000 1 0 3", bif.res_out, bif.zero_out, bif.parity_out, bif.op_out); end
        bif.out_ready_in = 1'b1;
        tick();
        bif.out_ready_in = 1'b0;
        tests_run++; if (bif.zero_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL zero_when_empty got %b expected 0", bif.zero_out); end
    endtask

    task automatic test_async_reset();
        set_ab(4'b1010, 4'b0110);
        push_one(3'd0);
        push_one(3'd1);
        push_one(3'd2);
        tests_run++; if (bif.count_out !== 3'd3) begin tests_failed++; $display("[TB] FAIL async_prefill got %0d expected 3", bif.count_out); end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++; if (bif.out_valid_out !== 1'b0 || bif.count_out !== 3'd0 || bif.in_ready_out !== 1'b1) begin tests_failed++; $display("[TB] FAIL async_reset got valid=%b count=%0d ready=%b expected 0 0 1", bif.out_valid_out, bif.count_out, bif.in_ready_out); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        push_one(3'd5);
        tests_run++; if (bif.count_out !== 3'd1 || bif.res_out !== 4'b1100 || bif.op_out !== 3'd5) begin tests_failed++; $display("[TB] FAIL async_after got count=%0d res=%b op=%0d expected 1 1100 5", bif.count_out, bif.res_out, bif.op_out); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_basic();
        test_fill_full();
        test_back_to_back();
        test_illegal_op();
        test_zero_flag();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
